// File: rtl/adler32_arbiter.sv
// adler32_arbiter
// Round-robin owner of the single shared adler32 engine. One requester holds
// the engine for a whole message; its bytes are forwarded one cycle after
// acceptance, the engine checksum is collected and reported with the
// requester id and byte count. REPORT plus IDLE keep the engine idle for at
// least two cycles between messages.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no owner; pick next requester from the rotating pointer
// STREAM    | owner's bytes accepted and forwarded to the engine
// WAIT_CSUM | last byte sent; waiting for checksum or timer expiry
// REPORT    | one-cycle done pulse; owner released

module adler32_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 8
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   eng_data_valid,
   output logic [7:0]             eng_data,
   output logic                   eng_last_data,
   input  logic                   eng_checksum_valid,
   input  logic [31:0]            eng_checksum,
   output logic                   done_valid,
   output logic [ID_W-1:0]        done_id,
   output logic [31:0]            done_checksum,
   output logic [15:0]            done_len,
   output logic                   done_err
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STREAM    = 2'd1,
      WAIT_CSUM = 2'd2,
      REPORT    = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]   grant_id, grant_id_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [15:0]       byte_cnt, byte_cnt_nxt;
   logic [TMR_W-1:0]  tmr, tmr_nxt;

   logic              eng_data_valid_nxt;
   logic [7:0]        eng_data_nxt;
   logic              eng_last_data_nxt;
   logic              done_valid_nxt;
   logic [ID_W-1:0]   done_id_nxt;
   logic [31:0]       done_checksum_nxt;
   logic [15:0]       done_len_nxt;
   logic              done_err_nxt;

   logic              found;
   logic [ID_W-1:0]   win_id;
   logic              g_valid;
   logic [7:0]        g_data;
   logic              g_last;
   logic              accept;

   assign req_ready = (state == STREAM) ? grant : '0;
   assign accept    = (state == STREAM) && g_valid;

   // First pending requester at or above rr_ptr, wrapping; two passes keep
   // every index a constant.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      for (int i = 0; i < 2 * NUM_REQ; i++) begin
         if (!found && (i >= int'(rr_ptr)) && req[i % NUM_REQ]) begin
            found  = 1'b1;
            win_id = ID_W'(i % NUM_REQ);
         end
      end
   end

   // Owner's byte lane, selected by the one-hot grant.
   always_comb begin
      g_valid = 1'b0;
      g_data  = 8'h00;
      g_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            g_valid = req_valid[i];
            g_data  = req_data[8*i +: 8];
            g_last  = req_last[i];
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt          = state;
      rr_ptr_nxt         = rr_ptr;
      grant_nxt          = grant;
      grant_id_nxt       = grant_id;
      byte_cnt_nxt       = byte_cnt;
      tmr_nxt            = tmr;
      eng_data_valid_nxt = 1'b0;
      eng_data_nxt       = eng_data;
      eng_last_data_nxt  = 1'b0;
      done_valid_nxt     = 1'b0;
      done_id_nxt        = done_id;
      done_checksum_nxt  = done_checksum;
      done_len_nxt       = done_len;
      done_err_nxt       = done_err;

      case (state)
         IDLE: begin
            if (found) begin
               grant_nxt         = '0;
               grant_nxt[win_id] = 1'b1;
               grant_id_nxt      = win_id;
               rr_ptr_nxt        = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
               byte_cnt_nxt      = 16'd0;
               state_nxt         = STREAM;
            end
         end

         STREAM: begin
            if (accept) begin
               eng_data_valid_nxt = 1'b1;
               eng_data_nxt       = g_data;
               eng_last_data_nxt  = g_last;
               if (byte_cnt != 16'hFFFF) begin
                  byte_cnt_nxt = byte_cnt + 16'd1;
               end
               if (g_last) begin
                  tmr_nxt   = TMR_W'(TIMEOUT);
                  state_nxt = WAIT_CSUM;
               end
            end
         end

         WAIT_CSUM: begin
            // Down-counter reaching terminal count marks TIMEOUT cycles spent here.
            if (eng_checksum_valid) begin
               done_checksum_nxt = eng_checksum;
               done_err_nxt      = 1'b0;
               done_valid_nxt    = 1'b1;
               done_id_nxt       = grant_id;
               done_len_nxt      = byte_cnt;
               state_nxt         = REPORT;
            end else if (tmr <= TMR_W'(1)) begin
               tmr_nxt           = '0;
               done_checksum_nxt = 32'h0;
               done_err_nxt      = 1'b1;
               done_valid_nxt    = 1'b1;
               done_id_nxt       = grant_id;
               done_len_nxt      = byte_cnt;
               state_nxt         = REPORT;
            end else begin
               tmr_nxt = tmr - TMR_W'(1);
            end
         end

         REPORT: begin
            grant_nxt = '0;
            tmr_nxt   = '0;
            state_nxt = IDLE;
         end

         default: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         grant          <= '0;
         grant_id       <= '0;
         byte_cnt       <= 16'd0;
         tmr            <= '0;
         eng_data_valid <= 1'b0;
         eng_data       <= 8'h00;
         eng_last_data  <= 1'b0;
         done_valid     <= 1'b0;
         done_id        <= '0;
         done_checksum  <= 32'h0;
         done_len       <= 16'd0;
         done_err       <= 1'b0;
      end else begin
         state          <= state_nxt;
         rr_ptr         <= rr_ptr_nxt;
         grant          <= grant_nxt;
         grant_id       <= grant_id_nxt;
         byte_cnt       <= byte_cnt_nxt;
         tmr            <= tmr_nxt;
         eng_data_valid <= eng_data_valid_nxt;
         eng_data       <= eng_data_nxt;
         eng_last_data  <= eng_last_data_nxt;
         done_valid     <= done_valid_nxt;
         done_id        <= done_id_nxt;
         done_checksum  <= done_checksum_nxt;
         done_len       <= done_len_nxt;
         done_err       <= done_err_nxt;
      end
   end

endmodule

// File: tb/tb_adler32_arbiter.sv
// Bench for adler32_arbiter with a behavioural adler32 engine on the engine side.

module tb_adler32_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 8;

   logic                 clock = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NUM_REQ-1:0]   req = '0;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [8*NUM_REQ-1:0] req_data = '0;
   logic [NUM_REQ-1:0]   req_last = '0;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   grant;
   logic                 eng_data_valid;
   logic [7:0]           eng_data;
   logic                 eng_last_data;
   logic                 eng_checksum_valid;
   logic [31:0]          eng_checksum;
   logic                 done_valid;
   logic [ID_W-1:0]      done_id;
   logic [31:0]          done_checksum;
   logic [15:0]          done_len;
   logic                 done_err;

   adler32_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clock              (clock),
      .rst_n              (rst_n),
      .req                (req),
      .req_valid          (req_valid),
      .req_data           (req_data),
      .req_last           (req_last),
      .req_ready          (req_ready),
      .grant              (grant),
      .eng_data_valid     (eng_data_valid),
      .eng_data           (eng_data),
      .eng_last_data      (eng_last_data),
      .eng_checksum_valid (eng_checksum_valid),
      .eng_checksum       (eng_checksum),
      .done_valid         (done_valid),
      .done_id            (done_id),
      .done_checksum      (done_checksum),
      .done_len           (done_len),
      .done_err           (done_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Engine model: checksum_valid one cycle after last_data, unless muted.
   bit          engine_mute = 1'b0;
   logic [15:0] m_a, m_b;

   function automatic logic [31:0] adl_step(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] d);
      int na, nb;
      na = (int'(a) + int'(d)) % 65521;
      nb = (int'(b) + na) % 65521;
      return {nb[15:0], na[15:0]};
   endfunction

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_a                <= 16'd1;
         m_b                <= 16'd0;
         eng_checksum_valid <= 1'b0;
         eng_checksum       <= 32'h0;
      end else begin
         eng_checksum_valid <= 1'b0;
         if (eng_data_valid) begin
            if (eng_last_data) begin
               eng_checksum_valid <= !engine_mute;
               eng_checksum       <= adl_step(m_a, m_b, eng_data);
               m_a                <= 16'd1;
               m_b                <= 16'd0;
            end else begin
               {m_b, m_a} <= adl_step(m_a, m_b, eng_data);
            end
         end
      end
   end

   // Engine-side monitor.
   int          dv_total    = 0;
   logic [31:0] dv_shift    = 32'h0;
   int          dv_last_cyc = -1;
   int          overlap_cnt = 0;
   int          last_ld_cyc = -1;
   int          min_gap     = 1000;
   int          done_cnt    = 0;

   always @(negedge clock) begin
      if (eng_data_valid) begin
         dv_total    <= dv_total + 1;
         dv_shift    <= {dv_shift[23:0], eng_data};
         dv_last_cyc <= cyc;
         if (last_ld_cyc >= 0 && (cyc - last_ld_cyc - 1) < min_gap) begin
            min_gap <= cyc - last_ld_cyc - 1;
         end
      end
      if (eng_last_data) last_ld_cyc <= cyc;
      if (eng_data_valid && eng_checksum_valid) overlap_cnt <= overlap_cnt + 1;
      if (done_valid) done_cnt <= done_cnt + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (grant != '0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL grant_wait: actual no grant, required a grant within 30 cycles");
      end
   endtask

   task automatic wait_done(output int t);
      t = -1;
      for (int i = 0; i < 40; i++) begin
         if (done_valid) begin
            t = cyc;
            break;
         end
         @(negedge clock);
      end
      if (t < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_wait: actual no done_valid, required one within 40 cycles");
      end
   endtask

   task automatic send_byte(input int id, input logic [7:0] d, input bit last, output int t_acc);
      req_valid[id]        = 1'b1;
      req_data[8*id +: 8]  = d;
      req_last[id]         = last;
      for (int i = 0; i < 30 && !req_ready[id]; i++) @(negedge clock);
      if (!req_ready[id]) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_wait: actual req_ready[%0d]=0, required 1 within 30 cycles", id);
      end
      t_acc = cyc;
      @(negedge clock);
      req_valid[id]       = 1'b0;
      req_last[id]        = 1'b0;
      req_data[8*id +: 8] = 8'h00;
   endtask

   task automatic run_msg(input int gid, input logic [3:0] req_before, input logic [3:0] req_after,
                          input int n, input logic [31:0] bytes, input int gap,
                          input logic [31:0] csum, input bit err, input int lat, input string tag);
      bit          ok;
      int          t_last, t_done, dv0;
      logic [31:0] exp_sh, mask;
      req = req_before;
      wait_grant(ok);
      check({tag, "_grant"}, 32'(grant), 32'(1) << gid);
      check({tag, "_ready"}, 32'(req_ready), 32'(1) << gid);
      dv0    = dv_total;
      t_last = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) repeat (gap) @(negedge clock);
         send_byte(gid, bytes[8*i +: 8], (i == n - 1), t_last);
      end
      req = req_after;
      check({tag, "_last_data"}, 32'(eng_last_data), 32'd1);
      wait_done(t_done);
      check({tag, "_latency"}, 32'(t_done - t_last), 32'(lat));
      check({tag, "_done_id"}, 32'(done_id), 32'(gid));
      check({tag, "_checksum"}, done_checksum, csum);
      check({tag, "_len"}, 32'(done_len), 32'(n));
      check({tag, "_err"}, 32'(done_err), 32'(err));
      @(negedge clock);
      check({tag, "_pulse"}, 32'(done_valid), 32'd0);
      check({tag, "_release"}, 32'(grant), 32'd0);
      check({tag, "_hold"}, done_checksum, csum);
      exp_sh = 32'h0;
      mask   = 32'h0;
      for (int i = 0; i < n; i++) begin
         exp_sh = {exp_sh[23:0], bytes[8*i +: 8]};
         mask   = {mask[23:0], 8'hFF};
      end
      check({tag, "_dv_count"}, 32'(dv_total - dv0), 32'(n));
      check({tag, "_dv_bytes"}, dv_shift & mask, exp_sh);
      check({tag, "_dv_timing"}, 32'(dv_last_cyc), 32'(t_last + 1));
   endtask

   typedef struct {
      int          id;
      int          n;
      logic [31:0] bytes;
      int          gap;
      logic [31:0] csum;
   } vec_t;

   vec_t tbl [4];
   int   rot_order [5];

   initial begin
      bit ok;
      int t, dc0;

      tbl[0] = '{id: 0, n: 1, bytes: 32'h0000_0061, gap: 0, csum: 32'h0062_0062};
      tbl[1] = '{id: 2, n: 3, bytes: 32'h0063_6261, gap: 2, csum: 32'h024D_0127};
      tbl[2] = '{id: 1, n: 2, bytes: 32'h0000_6261, gap: 0, csum: 32'h0126_00C4};
      tbl[3] = '{id: 3, n: 4, bytes: 32'h8001_00FF, gap: 1, csum: 32'h0482_0181};
      rot_order = '{0, 1, 2, 3, 0};

      repeat (3) @(negedge clock);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_eng_dv", 32'(eng_data_valid), 32'd0);
      check("rst_done_valid", 32'(done_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clock);
      check("idle_no_grant", 32'(grant), 32'd0);

      for (int v = 0; v < 4; v++) begin
         run_msg(tbl[v].id, 4'(1 << tbl[v].id), 4'b0000, tbl[v].n, tbl[v].bytes, tbl[v].gap,
                 tbl[v].csum, 1'b0, 3, $sformatf("vec%0d", v));
      end

      engine_mute = 1'b1;
      run_msg(1, 4'b0010, 4'b0000, 2, 32'h0000_2010, 0, 32'h0, 1'b1, 9, "timeout");
      engine_mute = 1'b0;
      run_msg(2, 4'b0100, 4'b0000, 1, 32'h0000_0061, 0, 32'h0062_0062, 1'b0, 3, "after_to");

      // Reset in the middle of a five-byte message.
      req = 4'b0010;
      wait_grant(ok);
      check("mid_grant", 32'(grant), 32'h2);
      send_byte(1, 8'h11, 1'b0, t);
      send_byte(1, 8'h22, 1'b0, t);
      dc0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("arst_grant", 32'(grant), 32'd0);
      check("arst_ready", 32'(req_ready), 32'd0);
      check("arst_eng_dv", 32'(eng_data_valid), 32'd0);
      check("arst_eng_data", 32'(eng_data), 32'd0);
      check("arst_eng_last", 32'(eng_last_data), 32'd0);
      check("arst_done_valid", 32'(done_valid), 32'd0);
      check("arst_done_id", 32'(done_id), 32'd0);
      check("arst_done_csum", done_checksum, 32'd0);
      check("arst_done_len", 32'(done_len), 32'd0);
      check("arst_done_err", 32'(done_err), 32'd0);
      req = 4'b0000;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      repeat (4) @(negedge clock);
      check("arst_no_done", 32'(done_cnt), 32'(dc0));
      check("arst_idle", 32'(grant), 32'd0);

      // All requesters pending: strict rotation from requester 0.
      for (int k = 0; k < 5; k++) begin
         run_msg(rot_order[k], 4'b1111, (k == 4) ? 4'b1001 : 4'b1111, 1, 32'h61, 0,
                 32'h0062_0062, 1'b0, 3, $sformatf("rot%0d", k));
      end
      run_msg(3, 4'b1001, 4'b1001, 1, 32'h61, 0, 32'h0062_0062, 1'b0, 3, "ptr_a");
      run_msg(0, 4'b1001, 4'b0000, 1, 32'h61, 0, 32'h0062_0062, 1'b0, 3, "ptr_b");

      // Back-to-back messages from one requester.
      run_msg(2, 4'b0100, 4'b0100, 2, 32'h6261, 0, 32'h0126_00C4, 1'b0, 3, "b2b0");
      run_msg(2, 4'b0100, 4'b0100, 2, 32'h6261, 0, 32'h0126_00C4, 1'b0, 3, "b2b1");
      run_msg(2, 4'b0100, 4'b0000, 2, 32'h6261, 0, 32'h0126_00C4, 1'b0, 3, "b2b2");
      repeat (2) @(negedge clock);
      check("gap_at_least_2", 32'(min_gap >= 2), 32'd1);
      check("no_dv_csum_overlap", 32'(overlap_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: actual simulation still running, required completion");
      $fatal(1, "bench timeout");
   end

endmodule
